// File: rtl/mod12289_s.sv
// Three-stage pipelined signed reducer modulo q = 12289 (27-bit signed in, 14-bit signed residue out).
// Define MOD12289S_CENTERED_EN to force the centered residue -6144..6144; otherwise any congruent 14-bit value.
module mod12289_s (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [26:0] inZ,
    output logic signed [13:0] outZ
);

    localparam logic signed [15:0] Q = 16'sd12289;
`ifdef MOD12289S_CENTERED_EN
    localparam logic signed [15:0] HI_B = 16'sd6144;
    localparam logic signed [15:0] LO_B = -16'sd6144;
`else
    localparam logic signed [15:0] HI_B = 16'sd8191;
    localparam logic signed [15:0] LO_B = -16'sd8192;
`endif

    // Stage 1: c1 ~ floor(inZ / 12288) as (inZ>>>12)*5461>>>14; subtract c1*q.
    logic signed [14:0] a1;
    logic signed [28:0] a1_x;
    logic signed [28:0] p1;
    logic signed [14:0] c1;
    logic signed [27:0] c1_x;
    logic signed [27:0] cq1;
    logic signed [27:0] r1_full;
    logic signed [15:0] r1_d, r1_q;

    always_comb begin
        a1      = 15'(inZ >>> 12);
        a1_x    = {{14{a1[14]}}, a1};
        p1      = (a1_x <<< 12) + (a1_x <<< 10) + (a1_x <<< 8) + (a1_x <<< 6)
                + (a1_x <<< 4) + (a1_x <<< 2) + a1_x;
        c1      = 15'(p1 >>> 14);
        c1_x    = {{13{c1[14]}}, c1};
        cq1     = (c1_x <<< 13) + (c1_x <<< 12) + c1_x;
        r1_full = {inZ[26], inZ} - cq1;
        r1_d    = 16'(r1_full);
    end

    // Stage 2: r1 lies in -5460..20479; a rounded quotient brings it to -4098..8192.
    logic signed [3:0]  a2;
    logic signed [17:0] a2_x;
    logic signed [17:0] t2;
    logic signed [3:0]  c2;
    logic signed [15:0] c2_x;
    logic signed [15:0] cq2;
    logic signed [15:0] r2_d, r2_q;

    always_comb begin
        a2   = 4'(r1_q >>> 12);
        a2_x = {{14{a2[3]}}, a2};
        t2   = (a2_x <<< 12) + (a2_x <<< 10) + (a2_x <<< 8) + (a2_x <<< 6)
             + (a2_x <<< 4) + (a2_x <<< 2) + a2_x + 18'sd8192;
        c2   = 4'(t2 >>> 14);
        c2_x = {{12{c2[3]}}, c2};
        cq2  = (c2_x <<< 13) + (c2_x <<< 12) + c2_x;
        r2_d = r1_q - cq2;
    end

    // Stage 3: single +-q correction into the output window.
    logic signed [15:0] r3;
    logic signed [13:0] out_d, out_q;

    always_comb begin
        r3 = r2_q;
        if (r2_q > HI_B) begin
            r3 = r2_q - Q;
        end else if (r2_q < LO_B) begin
            r3 = r2_q + Q;
        end
        out_d = 14'(r3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q  <= '0;
            r2_q  <= '0;
            out_q <= '0;
        end else begin
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            out_q <= out_d;
        end
    end

    assign outZ = out_q;

endmodule

// File: tb/tb_mod12289_s.sv
// Self-checking bench for mod12289_s: directed corner values, held inputs, random streaming
// with a mid-stream reset, all compared against a plain-arithmetic residue model.
module tb_mod12289_s;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [26:0] inZ;
  logic signed [13:0] outZ;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic r;
    int   x;
  } ent_t;

  ent_t hist[$];

  mod12289_s dut (
    .clk  (clk),
    .rst  (rst),
    .inZ  (inZ),
    .outZ (outZ)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Centered residue in -6144..6144 from plain integer arithmetic.
  function automatic int ref_res(input int x);
    int r;
    r = x % 12289;
    if (r < 0) r += 12289;
    if (r > 6144) r -= 12289;
    return r;
  endfunction

  function automatic int rand27();
    logic [26:0] u;
    u = 27'($urandom());
    return int'($signed(u));
  endfunction

  // Drive one input for one clock edge, then check the output produced by that edge.
  task automatic step(input int x, input logic r);
    ent_t e_new;
    logic flushed;
    int   o;
    int   e;
    inZ = 27'(x);
    rst = r;
    @(posedge clk);
    e_new.r = r;
    e_new.x = x;
    hist.push_back(e_new);
    if (hist.size() > 3) void'(hist.pop_front());
    @(negedge clk);
    flushed = (hist.size() < 3);
    foreach (hist[i]) if (hist[i].r) flushed = 1'b1;
    o = outZ;
    if (flushed) begin
      check_eq("flush_zero", o, 0);
    end else begin
      e = ref_res(hist[0].x);
`ifndef MOD12289S_CENTERED_EN
      if (o - 12289 == e) o = o - 12289;
      else if (o + 12289 == e) o = o + 12289;
`endif
      check_eq($sformatf("residue x=%0d", hist[0].x), o, e);
    end
  endtask

  int dir_vals[] = '{0, 12289, -1, 6144, 6145, 67108863, -67108864, -6144,
                     -6145, 8191, -8192, 8192, -8193, 12288, -12289, 24578,
                     24577, 6143, 67108862, -67108863, 67097940, -67097940,
                     4095, 4096, -4096, -4097, 20479, 1};

  initial begin
    int x;
    int sel;
    rst = 1'b1;
    inZ = '0;

    // reset held two cycles with arbitrary input, then two flushed cycles
    step(rand27(), 1'b1);
    step(rand27(), 1'b1);

    foreach (dir_vals[i]) step(dir_vals[i], 1'b0);

    // inputs held for four cycles each
    for (int i = 0; i < 16; i++) begin
      x = rand27();
      for (int k = 0; k < 4; k++) step(x, 1'b0);
    end

    // back-to-back random streaming with one mid-stream reset pulse
    for (int i = 0; i < 6000; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       x = $urandom_range(0, 40000) - 20000;
        1:       x = 67108863 - $urandom_range(0, 30000);
        2:       x = -67108864 + $urandom_range(0, 30000);
        default: x = rand27();
      endcase
      step(x, (i == 3000) ? 1'b1 : 1'b0);
    end

    for (int i = 0; i < 3; i++) step(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
